// File: rtl/tinyqv_bus_router.sv
// TinyQV data-bus router: combinational memory passthrough plus a registered,
// handshaked path to NUM_PERIPH peripheral ports. Define TINYQV_BUS_TIMEOUT_EN for the peripheral wait timeout.
module tinyqv_bus_router #(
    parameter int NUM_PERIPH     = 4,
    parameter int PSEL_LSB       = 24,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [27:0]             cpu_addr,
    input  logic [1:0]              cpu_write_n,
    input  logic [1:0]              cpu_read_n,
    input  logic [31:0]             cpu_data_out,
    output logic                    cpu_ready,
    output logic [31:0]             cpu_data_in,
    output logic                    bus_err,
    output logic [1:0]              mem_write_n,
    output logic [1:0]              mem_read_n,
    input  logic                    mem_ready,
    input  logic [31:0]             mem_data,
    output logic [27:0]             per_addr,
    output logic [31:0]             per_data_out,
    output logic [2*NUM_PERIPH-1:0] per_write_n,
    output logic [2*NUM_PERIPH-1:0] per_read_n,
    input  logic [NUM_PERIPH-1:0]   per_ready,
    input  logic [32*NUM_PERIPH-1:0] per_data_in
);

    if (NUM_PERIPH < 1 || NUM_PERIPH > 16) begin : g_bad_num_periph
        $error("NUM_PERIPH must be 1..16");
    end
    if (PSEL_LSB < 0 || PSEL_LSB > 24) begin : g_bad_psel_lsb
        $error("PSEL_LSB must be 0..24");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be 1..65535");
    end

    typedef enum logic [1:0] {IDLE, PERIPH, DONE} state_t;

    typedef struct packed {
        logic [1:0] write_n;
        logic [1:0] read_n;
    } strobe_t;

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    strobe_t     stb_q, stb_d;
    logic [27:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

`ifdef TINYQV_BUS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q, cnt_d;
`endif

    logic        req;
    logic        is_mem;
    logic        mapped;
    logic [3:0]  psel;
    strobe_t     cpu_stb;
    logic        sel_ready;
    logic [31:0] sel_rdata;

    assign psel   = cpu_addr[PSEL_LSB+3:PSEL_LSB];
    assign is_mem = (cpu_addr[27:25] == 3'b000);
    assign mapped = ({28'd0, psel} < 32'(NUM_PERIPH));
    assign req    = (cpu_write_n != 2'b11) || (cpu_read_n != 2'b11);

    // A write suppresses a simultaneous read so targets only ever see one strobe.
    assign cpu_stb.write_n = cpu_write_n;
    assign cpu_stb.read_n  = (cpu_write_n != 2'b11) ? 2'b11 : cpu_read_n;

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (sel_q == 4'(i)) begin
                sel_ready = per_ready[i];
                sel_rdata = per_data_in[32*i +: 32];
            end
        end
    end

    for (genvar i = 0; i < NUM_PERIPH; i++) begin : g_port
        assign per_write_n[2*i +: 2] = (state_q == PERIPH && sel_q == 4'(i)) ? stb_q.write_n : 2'b11;
        assign per_read_n[2*i +: 2]  = (state_q == PERIPH && sel_q == 4'(i)) ? stb_q.read_n  : 2'b11;
    end

    assign per_addr     = addr_q;
    assign per_data_out = wdata_q;

    assign mem_write_n = (state_q == IDLE && is_mem) ? cpu_stb.write_n : 2'b11;
    assign mem_read_n  = (state_q == IDLE && is_mem) ? cpu_stb.read_n  : 2'b11;

    always_comb begin
        cpu_ready   = 1'b0;
        cpu_data_in = rdata_q;
        bus_err     = 1'b0;
        if (state_q == IDLE && req && is_mem) begin
            cpu_ready   = mem_ready;
            cpu_data_in = mem_data;
        end else if (state_q == DONE) begin
            cpu_ready = 1'b1;
            bus_err   = err_q;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        stb_d   = stb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef TINYQV_BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req && !is_mem) begin
                    if (mapped) begin
                        state_d = PERIPH;
                        sel_d   = psel;
                        stb_d   = cpu_stb;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_data_out;
                        err_d   = 1'b0;
`ifdef TINYQV_BUS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = DONE;
                        rdata_d = 32'hFFFF_FFFF;
                        err_d   = 1'b1;
                    end
                end
            end
            PERIPH: begin
                // A response on the limit cycle still counts as a normal completion.
                if (sel_ready) begin
                    state_d = DONE;
                    rdata_d = sel_rdata;
                    err_d   = 1'b0;
                end
`ifdef TINYQV_BUS_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LIM) begin
                    state_d = DONE;
                    rdata_d = 32'hFFFF_FFFF;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            stb_q   <= '{write_n: 2'b11, read_n: 2'b11};
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef TINYQV_BUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            stb_q   <= stb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef TINYQV_BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_tinyqv_bus_router.sv
// Scoreboard bench for tinyqv_bus_router: a driver issues directed and random
// transactions and plays the targets; a monitor checks every cpu_ready completion.
module tb_tinyqv_bus_router;

    localparam int NP   = 4;
    localparam int PSEL = 20;
    localparam int TO   = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [27:0]          cpu_addr = '0;
    logic [1:0]           cpu_write_n = 2'b11;
    logic [1:0]           cpu_read_n = 2'b11;
    logic [31:0]          cpu_data_out = '0;
    logic                 cpu_ready;
    logic [31:0]          cpu_data_in;
    logic                 bus_err;
    logic [1:0]           mem_write_n;
    logic [1:0]           mem_read_n;
    logic                 mem_ready = 1'b0;
    logic [31:0]          mem_data = '0;
    logic [27:0]          per_addr;
    logic [31:0]          per_data_out;
    logic [2*NP-1:0]      per_write_n;
    logic [2*NP-1:0]      per_read_n;
    logic [NP-1:0]        per_ready = '0;
    logic [32*NP-1:0]     per_data_in = '0;

    tinyqv_bus_router #(.NUM_PERIPH(NP), .PSEL_LSB(PSEL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_write_n(cpu_write_n), .cpu_read_n(cpu_read_n),
        .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready), .cpu_data_in(cpu_data_in),
        .bus_err(bus_err), .mem_write_n(mem_write_n), .mem_read_n(mem_read_n),
        .mem_ready(mem_ready), .mem_data(mem_data), .per_addr(per_addr),
        .per_data_out(per_data_out), .per_write_n(per_write_n), .per_read_n(per_read_n),
        .per_ready(per_ready), .per_data_in(per_data_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          chkd;
        int          lat;
        int          start;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (cpu_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ready: cpu_ready=1 with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("latency", 64'(cyc - mon_e.start), 64'(mon_e.lat));
                    chk("bus_err", bus_err, mon_e.err);
                    if (mon_e.chkd) chk("rdata", cpu_data_in, mon_e.data);
                end
            end else begin
                chk("bus_err_idle", bus_err, 1'b0);
            end
        end
    end

    // One CPU transaction; k is the target response cycle (mem: ready cycle,
    // peripheral: per_ready cycle >= 1). no_rdy keeps the peripheral silent.
    task automatic txn(input logic [27:0] a, input logic [1:0] wn, input logic [1:0] rn,
                       input logic [31:0] wd, input logic [31:0] rsp, input int k, input bit no_rdy);
        exp_t            e;
        bit              mem, mapped, wr;
        int              p;
        logic [1:0]      swn, srn;
        logic [2*NP-1:0] exp_pw, exp_pr;
        mem    = (a[27:25] == 3'b000);
        p      = int'(a[PSEL +: 4]);
        mapped = !mem && (p < NP);
        wr     = (wn != 2'b11);
        swn    = wn;
        srn    = wr ? 2'b11 : rn;
        e.start = cyc;
        e.chkd  = !wr || (!mem && !mapped) || no_rdy;
        if (mem) begin
            e.data = rsp; e.err = 1'b0; e.lat = k;
        end else if (!mapped) begin
            e.data = 32'hFFFF_FFFF; e.err = 1'b1; e.lat = 1;
        end else if (no_rdy) begin
            e.data = 32'hFFFF_FFFF; e.err = 1'b1; e.lat = k + 1;
        end else begin
            e.data = rsp; e.err = 1'b0; e.lat = k + 1;
        end
        exp_q.push_back(e);
        cpu_addr = a; cpu_write_n = wn; cpu_read_n = rn; cpu_data_out = wd;
        for (int j = 0; j <= e.lat; j++) begin
            mem_ready = mem && (j == k);
            mem_data  = (mem && j == k) ? rsp : $urandom;
            for (int i = 0; i < NP; i++) begin
                per_ready[i] = ($urandom_range(0, 3) == 0);
                per_data_in[32*i +: 32] = $urandom;
            end
            if (mapped) begin
                per_ready[p] = !no_rdy && (j == k);
                if (j == k) per_data_in[32*p +: 32] = rsp;
            end
            @(negedge clk);
            exp_pw = '1;
            exp_pr = '1;
            if (mapped && j >= 1 && j <= k) begin
                exp_pw[2*p +: 2] = swn;
                exp_pr[2*p +: 2] = srn;
            end
            chk("per_write_n", per_write_n, exp_pw);
            chk("per_read_n", per_read_n, exp_pr);
            chk("mem_write_n", mem_write_n, mem ? swn : 2'b11);
            chk("mem_read_n", mem_read_n, mem ? srn : 2'b11);
            if (mapped && j >= 1) begin
                chk("per_addr", per_addr, a);
                chk("per_data_out", per_data_out, wd);
            end
            @(posedge clk);
            #1;
        end
        cpu_write_n = 2'b11; cpu_read_n = 2'b11;
        mem_ready = 1'b0; per_ready = '0;
    endtask

    function automatic logic [1:0] rand_stb();
        return 2'($urandom_range(0, 2));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] a;
        logic [1:0]  wn, rn;
        int          kind, p, k;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_per_write_n", per_write_n, {(2*NP){1'b1}});
        chk("rst_per_read_n", per_read_n, {(2*NP){1'b1}});
        chk("rst_mem_write_n", mem_write_n, 2'b11);
        chk("rst_mem_read_n", mem_read_n, 2'b11);
        chk("rst_per_addr", per_addr, 28'd0);
        chk("rst_per_data_out", per_data_out, 32'd0);
        chk("rst_cpu_ready", cpu_ready, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_cpu_data_in", cpu_data_in, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        txn(28'h0000100, 2'b11, 2'b10, 32'h0, 32'h1234_5678, 3, 1'b0);
        txn(28'h2200004, 2'b00, 2'b11, 32'h0000_00A5, 32'h0, 3, 1'b0);
        txn(28'h2100008, 2'b11, 2'b10, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
        txn(28'h2700000, 2'b11, 2'b10, 32'h0, 32'h0, 1, 1'b0);
        txn(28'h0000200, 2'b10, 2'b10, 32'h1111_2222, 32'h0, 0, 1'b0);
        txn(28'h6300010, 2'b01, 2'b00, 32'hBEEF_0001, 32'h0, 2, 1'b0);
        txn(28'h2F00000, 2'b00, 2'b11, 32'h5, 32'h0, 1, 1'b0);

`ifdef TINYQV_BUS_TIMEOUT_EN
        txn(28'h2000040, 2'b11, 2'b10, 32'h0, 32'h0, TO + 1, 1'b1);
        txn(28'h2000040, 2'b11, 2'b10, 32'h0, 32'h600D_600D, TO + 1, 1'b0);
`endif

        // Reset while a peripheral read to port 3 is outstanding.
        cpu_addr = 28'h2300010; cpu_write_n = 2'b11; cpu_read_n = 2'b10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_active_read_n", per_read_n[7:6], 2'b10);
        rst = 1'b1;
        cpu_read_n = 2'b11;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_per_read_n", per_read_n, {(2*NP){1'b1}});
        chk("midrst_per_write_n", per_write_n, {(2*NP){1'b1}});
        chk("midrst_per_addr", per_addr, 28'd0);
        @(posedge clk); #1;
        txn(28'h2300010, 2'b11, 2'b10, 32'h0, 32'h0BAD_CAFE, 2, 1'b0);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            a    = 28'($urandom);
            case ($urandom_range(0, 2))
                0:       begin wn = rand_stb(); rn = 2'b11; end
                1:       begin wn = 2'b11; rn = rand_stb(); end
                default: begin wn = rand_stb(); rn = rand_stb(); end
            endcase
            if (kind == 0) begin
                a[27:25] = 3'b000;
                k = $urandom_range(0, 4);
            end else begin
                p = (kind == 1) ? $urandom_range(0, NP - 1) : $urandom_range(NP, 15);
                a[PSEL +: 4] = 4'(p);
                if (a[27:25] == 3'b000) a[27] = 1'b1;
                k = $urandom_range(1, 5);
            end
            txn(a, wn, rn, $urandom, $urandom, k, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tinyqv_bus_router.md
# tinyqv_bus_router

Parametrised data-bus router between the TinyQV CPU data port and its targets: one QSPI memory controller and NUM_PERIPH peripheral ports. Memory transactions pass through combinationally. Peripheral transactions are decoded, registered and handshaked by a small FSM, with bus-error completion for unmapped addresses and an optional timeout. It replaces the fixed two-way memory/peripheral split at the CPU top level.

## Interface

Parameters:
- NUM_PERIPH, 4: number of peripheral ports, range 1..16.
- PSEL_LSB, 24: lowest address bit of the 4-bit peripheral select field, i.e. cpu_addr[PSEL_LSB+3:PSEL_LSB].
- TIMEOUT_CYCLES, 255: wait limit in cycles; range 1..65535; only used with the timeout macro.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  28  CPU data address.
- cpu_write_n  in  2  write strobe: 11 none, 00 8-bit, 01 16-bit, 10 32-bit.
- cpu_read_n  in  2  read strobe, same encoding as cpu_write_n.
- cpu_data_out  in  32  CPU write data.
- cpu_ready  out  1  transaction complete.
- cpu_data_in  out  32  read data returned to the CPU.
- bus_err  out  1  one-cycle pulse coincident with an error completion.
- mem_write_n  out  2  memory controller write strobe.
- mem_read_n  out  2  memory controller read strobe.
- mem_ready  in  1  memory controller ready.
- mem_data  in  32  memory controller read data.
- per_addr  out  28  registered peripheral address.
- per_data_out  out  32  registered peripheral write data.
- per_write_n  out  2*NUM_PERIPH  per-port write strobe; port i uses bits [2i+1:2i].
- per_read_n  out  2*NUM_PERIPH  per-port read strobe; same bit layout as per_write_n.
- per_ready  in  NUM_PERIPH  per-port ready.
- per_data_in  in  32*NUM_PERIPH  per-port read data; port i uses bits [32i+31:32i].

## Operation

Definitions:
- A request is present when cpu_write_n != 11 or cpu_read_n != 11.
- If both strobes are active, write wins and the read is ignored.
- is_mem = (cpu_addr[27:25] == 0).
- Port index p = cpu_addr[PSEL_LSB+3:PSEL_LSB].
- p >= NUM_PERIPH is unmapped.

FSM states: IDLE, PERIPH, DONE.
- IDLE, memory request:
  - mem_write_n/mem_read_n follow the CPU strobes combinationally.
  - cpu_ready = mem_ready; cpu_data_in = mem_data.
  - FSM stays in IDLE.
  - Outside IDLE, or when not is_mem, the mem strobes are 11.
- IDLE, peripheral request to mapped p:
  - Latch p, cpu_addr, cpu_data_out and the strobes.
  - Go to PERIPH; the timeout counter clears to 0.
- IDLE, peripheral request to unmapped p:
  - Load rdata = 32'hFFFF_FFFF and set err.
  - Go to DONE; no peripheral strobe is driven.
- PERIPH:
  - Only port p drives its latched strobes; all other ports drive 11.
  - When per_ready[p] = 1: capture per_data_in[p] into rdata (write data is don't-care), drop the strobes and go to DONE.
- DONE:
  - cpu_ready = 1, cpu_data_in = rdata, bus_err = err.
  - Next state is IDLE unconditionally. The CPU updates its request on this edge, so no request is issued twice.
- Outside the cases above, cpu_ready = 0 and cpu_data_in = rdata.

## Timing

- Reset values:
  - state = IDLE.
  - All per_* strobes and mem strobes = 11.
  - per_addr = 0, per_data_out = 0, rdata = 0.
  - cpu_ready = 0, bus_err = 0, counter = 0.
- Reset mid-transaction aborts it: the strobes drop on the next edge and no cpu_ready is produced.
- Memory path latency is 0 added cycles (pure combinational passthrough).
- Peripheral path:
  - Request seen in IDLE at cycle 0.
  - Strobes valid from cycle 1.
  - per_ready sampled at cycle k >= 1.
  - cpu_ready at cycle k+1.
  - Minimum total is 2 cycles.
- Unmapped access: cpu_ready and bus_err at cycle 1.
- A peripheral must hold per_ready for exactly one cycle per transaction. per_ready on a non-selected port is ignored.
- Back-to-back: a new request presented in the cycle after DONE is accepted in that IDLE cycle.

## Configuration

- TINYQV_BUS_TIMEOUT_EN defined:
  - In PERIPH the counter increments each cycle without per_ready.
  - When the counter reaches TIMEOUT_CYCLES, the strobes drop, rdata = 32'hFFFF_FFFF, err = 1, and the FSM goes to DONE.
  - If per_ready arrives in the same cycle as the limit, it wins and err = 0.
- Undefined:
  - No counter is implemented; PERIPH waits indefinitely.
  - bus_err is asserted only for unmapped accesses.

## Test plan

- Memory passthrough: read_n = 10 at addr 0x0000100, mem_ready high after 3 cycles with mem_data = 0x12345678 -> cpu_ready in the same cycle, cpu_data_in = 0x12345678, per strobes stay 11.
- Peripheral write: write_n = 00 to port 2, addr 0x2000004, data 0xA5 -> per_write_n[5:4] = 00 from cycle 1; per_ready[2] at cycle 3 -> cpu_ready at cycle 4, bus_err = 0.
- Peripheral read: port 1 responds with 0xCAFEF00D at cycle 1 -> cpu_data_in = 0xCAFEF00D with cpu_ready at cycle 2.
- Unmapped: NUM_PERIPH = 4, access port 7 -> cpu_ready and bus_err at cycle 1, data 0xFFFFFFFF, no strobes driven.
- Timeout (macro on, TIMEOUT_CYCLES = 8): port 0 never ready -> error completion with data 0xFFFFFFFF and bus_err = 1, strobes back to 11. Repeat with per_ready on the limit cycle -> normal completion, bus_err = 0.
- rst asserted during PERIPH -> strobes 11 next cycle, no cpu_ready; a following request completes normally.
